// File: rtl/tilt_angle_scheduler.sv
// Shares one vectoring CORDIC between the X and Y tilt axes and turns each angle pair into a
// debounced one-hot tilt direction with move pulses. Define AUTO_REPEAT_EN for held-tilt auto-repeat.
module tilt_angle_scheduler #(
  parameter int DW         = 10,
  parameter int TH_ON      = 30,
  parameter int TH_OFF     = 20,
  parameter int TIMEOUT    = 64,
  parameter int REPEAT_CYC = 12_500_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid_i,
  input  logic [DW-1:0] x_data_i,
  input  logic [DW-1:0] y_data_i,
  input  logic [DW-1:0] z_data_i,
  output logic          cordic_start_o,
  output logic [DW-1:0] cordic_x_o,
  output logic [DW-1:0] cordic_y_o,
  input  logic          cordic_done_i,
  input  logic [8:0]    cordic_angle_i,
  output logic [8:0]    angle_x_o,
  output logic [8:0]    angle_y_o,
  output logic          angles_valid_o,
  output logic [3:0]    tilt_dir_o,
  output logic          move_pulse_o,
  output logic          busy_o,
  output logic          timeout_err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic signed [8:0] ON_P  = 9'(TH_ON);
  localparam logic signed [8:0] ON_N  = 9'(-TH_ON);
  localparam logic signed [8:0] OFF_P = 9'(TH_OFF);
  localparam logic signed [8:0] OFF_N = 9'(-TH_OFF);

  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_R = 4'b0100;
  localparam logic [3:0] DIR_U = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_X,
    S_WAIT_X,
    S_REQ_Y,
    S_WAIT_Y,
    S_UPDATE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] x_cap_q, x_cap_d, y_cap_q, y_cap_d, z_cap_q, z_cap_d;
  logic [DW-1:0] x_pend_q, x_pend_d, y_pend_q, y_pend_d, z_pend_q, z_pend_d;
  logic          pend_q, pend_d;
  logic [8:0]    ang_tmp_q, ang_tmp_d;
  logic [8:0]    angle_x_q, angle_x_d, angle_y_q, angle_y_d;
  logic          angles_valid_q, angles_valid_d;
  logic [3:0]    tilt_dir_q, tilt_dir_d;
  logic          move_pulse_q, move_pulse_d;
  logic          timeout_err_q, timeout_err_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic          launch;
  logic          publish;
  logic          dir_change;
  logic          rep_fire;
  logic          hold;
  logic [3:0]    tilt_next;
  logic signed [8:0] eval_ax, eval_ay;

  // The pair being published is the stored X result plus the Y result arriving this cycle.
  assign eval_ax    = $signed(ang_tmp_q);
  assign eval_ay    = $signed(cordic_angle_i);
  assign publish    = (state_q == S_WAIT_Y) && cordic_done_i;
  assign dir_change = publish && (tilt_next != tilt_dir_q);

  always_comb begin
    hold      = 1'b0;
    tilt_next = 4'd0;
    case (tilt_dir_q)
      DIR_L:   hold = (eval_ax >= OFF_P);
      DIR_R:   hold = (eval_ax <= OFF_N);
      DIR_U:   hold = (eval_ay <= OFF_N);
      DIR_D:   hold = (eval_ay >= OFF_P);
      default: hold = 1'b0;
    endcase
    if (hold)                tilt_next = tilt_dir_q;
    else if (eval_ax > ON_P) tilt_next = DIR_L;
    else if (eval_ax < ON_N) tilt_next = DIR_R;
    else if (eval_ay > ON_P) tilt_next = DIR_D;
    else if (eval_ay < ON_N) tilt_next = DIR_U;
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_fire  = 1'b0;
    if (dir_change || (tilt_dir_q == 4'd0)) begin
      rep_cnt_d = '0;
    end else if (rep_cnt_q == RW'(REPEAT_CYC - 1)) begin
      rep_cnt_d = '0;
      rep_fire  = 1'b1;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_cnt_q <= '0;
    else        rep_cnt_q <= rep_cnt_d;
  end
`else
  // Single pulse per direction entry; REPEAT_CYC stays referenced but has no effect.
  assign rep_fire = 1'b0 & (REPEAT_CYC == 0);
`endif

  always_comb begin
    state_d        = state_q;
    x_cap_d        = x_cap_q;
    y_cap_d        = y_cap_q;
    z_cap_d        = z_cap_q;
    x_pend_d       = x_pend_q;
    y_pend_d       = y_pend_q;
    z_pend_d       = z_pend_q;
    pend_d         = pend_q;
    ang_tmp_d      = ang_tmp_q;
    angle_x_d      = angle_x_q;
    angle_y_d      = angle_y_q;
    angles_valid_d = 1'b0;
    tilt_dir_d     = tilt_dir_q;
    move_pulse_d   = rep_fire;
    timeout_err_d  = timeout_err_q;
    tmo_cnt_d      = tmo_cnt_q;
    launch         = 1'b0;

    if (sample_valid_i) begin
      x_pend_d = x_data_i;
      y_pend_d = y_data_i;
      z_pend_d = z_data_i;
      pend_d   = 1'b1;
    end

    case (state_q)
      S_IDLE: launch = sample_valid_i || pend_q;
      S_REQ_X: begin
        tmo_cnt_d = TW'(1);
        state_d   = S_WAIT_X;
      end
      S_WAIT_X: begin
        if (cordic_done_i) begin
          ang_tmp_d = cordic_angle_i;
          state_d   = S_REQ_Y;
        end else if (tmo_cnt_q == TW'(TIMEOUT)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_REQ_Y: begin
        tmo_cnt_d = TW'(1);
        state_d   = S_WAIT_Y;
      end
      S_WAIT_Y: begin
        if (cordic_done_i) begin
          angle_x_d      = ang_tmp_q;
          angle_y_d      = cordic_angle_i;
          angles_valid_d = 1'b1;
          tilt_dir_d     = tilt_next;
          if (dir_change && (tilt_next != 4'd0)) move_pulse_d = 1'b1;
          state_d = S_UPDATE;
        end else if (tmo_cnt_q == TW'(TIMEOUT)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_UPDATE: begin
        launch  = sample_valid_i || pend_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A strobe in the launching cycle is newer than anything buffered, so it wins.
    if (launch) begin
      x_cap_d = sample_valid_i ? x_data_i : x_pend_q;
      y_cap_d = sample_valid_i ? y_data_i : y_pend_q;
      z_cap_d = sample_valid_i ? z_data_i : z_pend_q;
      pend_d  = 1'b0;
      state_d = S_REQ_X;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      x_cap_q        <= '0;
      y_cap_q        <= '0;
      z_cap_q        <= '0;
      x_pend_q       <= '0;
      y_pend_q       <= '0;
      z_pend_q       <= '0;
      pend_q         <= 1'b0;
      ang_tmp_q      <= '0;
      angle_x_q      <= '0;
      angle_y_q      <= '0;
      angles_valid_q <= 1'b0;
      tilt_dir_q     <= '0;
      move_pulse_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
      tmo_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      x_cap_q        <= x_cap_d;
      y_cap_q        <= y_cap_d;
      z_cap_q        <= z_cap_d;
      x_pend_q       <= x_pend_d;
      y_pend_q       <= y_pend_d;
      z_pend_q       <= z_pend_d;
      pend_q         <= pend_d;
      ang_tmp_q      <= ang_tmp_d;
      angle_x_q      <= angle_x_d;
      angle_y_q      <= angle_y_d;
      angles_valid_q <= angles_valid_d;
      tilt_dir_q     <= tilt_dir_d;
      move_pulse_q   <= move_pulse_d;
      timeout_err_q  <= timeout_err_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  assign cordic_start_o = (state_q == S_REQ_X) || (state_q == S_REQ_Y);
  assign cordic_x_o     = z_cap_q;
  assign cordic_y_o     = ((state_q == S_REQ_Y) || (state_q == S_WAIT_Y)) ? y_cap_q : x_cap_q;
  assign angle_x_o      = angle_x_q;
  assign angle_y_o      = angle_y_q;
  assign angles_valid_o = angles_valid_q;
  assign tilt_dir_o     = tilt_dir_q;
  assign move_pulse_o   = move_pulse_q;
  assign busy_o         = (state_q != S_IDLE);
  assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_tilt_angle_scheduler.sv
// Directed bench for tilt_angle_scheduler: a CORDIC stand-in answers jobs from an angle queue,
// and a scoreboard of expected operand/pair results is checked as the DUT produces them.
module tb_tilt_angle_scheduler;

  localparam int DW = 10;
  localparam logic [3:0] L = 4'b1000, R = 4'b0100, U = 4'b0010, D = 4'b0001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] x_data = '0, y_data = '0, z_data = '0;
  logic          cordic_start;
  logic [DW-1:0] cordic_x, cordic_y;
  logic          cordic_done = 1'b0;
  logic [8:0]    cordic_angle = '0;
  logic [8:0]    angle_x, angle_y;
  logic          angles_valid;
  logic [3:0]    tilt_dir;
  logic          move_pulse, busy, timeout_err;

  tilt_angle_scheduler #(
    .DW(DW), .TH_ON(30), .TH_OFF(20), .TIMEOUT(64), .REPEAT_CYC(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid_i(sample_valid),
    .x_data_i(x_data), .y_data_i(y_data), .z_data_i(z_data),
    .cordic_start_o(cordic_start), .cordic_x_o(cordic_x), .cordic_y_o(cordic_y),
    .cordic_done_i(cordic_done), .cordic_angle_i(cordic_angle),
    .angle_x_o(angle_x), .angle_y_o(angle_y), .angles_valid_o(angles_valid),
    .tilt_dir_o(tilt_dir), .move_pulse_o(move_pulse), .busy_o(busy),
    .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; } op_t;
  typedef struct { int ax; int ay; logic [3:0] dir; logic mp; } pair_t;

  op_t   op_q[$];
  pair_t exp_q[$];
  int    ang_q[$];

  int n_cmp = 0, n_mis = 0;
  int cyc = 0, last_done_cyc = -10, n_valid = 0, n_move = 0;
  int delay = 3;
  bit mute = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // CORDIC stand-in: checks operands at each start, answers after `delay` cycles.
  always begin
    int a;
    op_t o;
    @(posedge clk);
    if (rst_n && cordic_start === 1'b1 && !mute) begin
      chk("op_present", (op_q.size() > 0), 1);
      if (op_q.size() > 0) begin
        o = op_q.pop_front();
        chk("op_cordic_x", $signed(cordic_x), o.x);
        chk("op_cordic_y", $signed(cordic_y), o.y);
      end
      a = (ang_q.size() > 0) ? ang_q.pop_front() : 0;
      repeat (delay - 1) @(posedge clk);
      #1;
      cordic_done   = 1'b1;
      cordic_angle  = 9'(a);
      last_done_cyc = cyc;
      @(posedge clk);
      #1;
      cordic_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    pair_t e;
    if (angles_valid === 1'b1) begin
      n_valid++;
      $display("pair @%0d: ax=%0d ay=%0d dir=%b pulse=%b", cyc, $signed(angle_x), $signed(angle_y), tilt_dir, move_pulse);
      chk("pair_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("angle_x", $signed(angle_x), e.ax);
        chk("angle_y", $signed(angle_y), e.ay);
        chk("tilt_dir", tilt_dir, e.dir);
        chk("move_pulse", move_pulse, e.mp);
        chk("valid_latency", cyc, last_done_cyc + 1);
      end
    end
    if (move_pulse === 1'b1) n_move++;
  end

  task automatic send(input int x, input int y, input int z);
    @(negedge clk);
    x_data = DW'(x); y_data = DW'(y); z_data = DW'(z);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic expect_job(input int x, input int y, input int z, input int a1, input int a2,
                            input logic [3:0] dir, input logic mp);
    op_q.push_back('{z, x});
    op_q.push_back('{z, y});
    ang_q.push_back(a1);
    ang_q.push_back(a2);
    exp_q.push_back('{a1, a2, dir, mp});
  endtask

  task automatic wait_pairs(input int target);
    int t = 0;
    while (n_valid < target && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("wait_pairs", n_valid, target);
  endtask

  initial begin
    int c0, m0, v0, t, exp_rep;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", cordic_start, 0);
    chk("rst_angle_x", angle_x, 0);
    chk("rst_tilt", tilt_dir, 0);
    chk("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic pair, start one cycle after the strobe
    expect_job(50, 0, 200, 40, 0, L, 1'b1);
    send(50, 0, 200);
    chk("t1_start_lat", cordic_start, 1);
    chk("t1_cordic_y", $signed(cordic_y), 50);
    chk("t1_cordic_x", $signed(cordic_x), 200);
    wait_pairs(1);
    repeat (3) @(negedge clk);
    chk("t1_moves", n_move, 1);
    chk("t1_idle", busy, 0);

    // 2: hysteresis on left
    expect_job(1, 2, 3, 25, 0, L, 1'b0);
    send(1, 2, 3);
    wait_pairs(2);
    expect_job(4, 5, 6, 19, 0, 4'd0, 1'b0);
    send(4, 5, 6);
    wait_pairs(3);
    expect_job(7, 8, 9, 25, 0, 4'd0, 1'b0);
    send(7, 8, 9);
    wait_pairs(4);
    repeat (3) @(negedge clk);
    chk("t2_moves", n_move, 1);

    // 3: three strobes during WAIT_X; only the last one runs afterwards
    delay = 8;
    expect_job(60, 10, 100, 35, -40, L, 1'b1);
    expect_job(70, -30, 120, 0, 45, D, 1'b1);
    send(60, 10, 100);
    send(1, 1, 1);
    send(2, 2, 2);
    send(70, -30, 120);
    wait_pairs(6);
    repeat (40) @(negedge clk);
    chk("t3_pairs", n_valid, 6);
    chk("t3_moves", n_move, 3);
    delay = 3;

    // 4: CORDIC never answers -> timeout
    mute = 1'b1;
    send(5, 5, 5);
    c0 = cyc;
    t = 0;
    while (timeout_err !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t4_timeout_err", timeout_err, 1);
    chk("t4_abort_cycles", cyc - c0, 65);
    chk("t4_idle", busy, 0);
    chk("t4_angle_x", $signed(angle_x), 0);
    chk("t4_angle_y", $signed(angle_y), 45);
    chk("t4_tilt", tilt_dir, D);
    chk("t4_no_valid", n_valid, 6);
    mute = 1'b0;

    // 5: priority, then release to up
    expect_job(11, 12, 13, 35, -50, L, 1'b1);
    send(11, 12, 13);
    wait_pairs(7);
    expect_job(14, 15, 16, 0, -50, U, 1'b1);
    send(14, 15, 16);
    wait_pairs(8);
    chk("t5_sticky_err", timeout_err, 1);

    // 6: hold left and count pulses over 250 cycles
    m0 = n_move;
    expect_job(17, 18, 19, 40, 0, L, 1'b1);
    send(17, 18, 19);
    wait_pairs(9);
    repeat (250) @(negedge clk);
`ifdef AUTO_REPEAT_EN
    exp_rep = 3;
`else
    exp_rep = 1;
`endif
    chk("t6_hold_pulses", n_move - m0, exp_rep);

    // Reset in the middle of WAIT_Y; the late done must be ignored
    delay = 10;
    v0 = n_valid;
    op_q.push_back('{23, 21});
    op_q.push_back('{23, 22});
    ang_q.push_back(10);
    ang_q.push_back(10);
    send(21, 22, 23);
    repeat (14) @(negedge clk);
    chk("rst_mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_tilt", tilt_dir, 0);
    chk("rst_mid_angle_y", angle_y, 0);
    chk("rst_mid_err", timeout_err, 0);
    chk("rst_mid_cordic_y", cordic_y, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("late_done_valid", n_valid, v0);
    chk("late_done_busy", busy, 0);
    chk("op_queue_empty", op_q.size(), 0);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
